// File: rtl/pdu_gen_param_if.sv
// Flit/metadata input, packet and descriptor ring-buffer writes, occupancy feedback and stats.
// slave = generator side, master = upstream pipeline / ring-buffer side.
interface pdu_gen_param_if #(
    parameter int DATA_W  = 512,
    parameter int EMPTY_W = 6,
    parameter int DSC_QW  = 11,
    parameter int PKT_QW  = 13,
    parameter int RB_AW   = 10
);
    logic [DATA_W-1:0]  in_data;
    logic               in_sop;
    logic               in_eop;
    logic [EMPTY_W-1:0] in_empty;
    logic               in_valid;
    logic               in_ready;
    logic               in_meta_valid;
    logic [DSC_QW-1:0]  in_meta_dsc_queue;
    logic [PKT_QW-1:0]  in_meta_pkt_queue;
    logic               in_meta_drop;
    logic               in_meta_ready;
    logic               pkt_wr_en;
    logic [DATA_W-1:0]  pkt_wr_data;
    logic               pkt_wr_sop;
    logic               pkt_wr_eop;
    logic [RB_AW-1:0]   pkt_occup;
    logic               desc_wr_en;
    logic [DSC_QW-1:0]  desc_wr_dsc_queue;
    logic [PKT_QW-1:0]  desc_wr_pkt_queue;
    logic [15:0]        desc_wr_bytes;
    logic [15:0]        desc_wr_flits;
    logic               desc_wr_trunc;
    logic [RB_AW-1:0]   desc_occup;
    logic [31:0]        stat_pkts;
    logic [31:0]        stat_drops;
    logic [31:0]        stat_truncs;

    modport slave (
        input  in_data, in_sop, in_eop, in_empty, in_valid, in_meta_valid,
               in_meta_dsc_queue, in_meta_pkt_queue, in_meta_drop, pkt_occup, desc_occup,
        output in_ready, in_meta_ready, pkt_wr_en, pkt_wr_data, pkt_wr_sop, pkt_wr_eop,
               desc_wr_en, desc_wr_dsc_queue, desc_wr_pkt_queue, desc_wr_bytes, desc_wr_flits,
               desc_wr_trunc, stat_pkts, stat_drops, stat_truncs
    );

    modport master (
        output in_data, in_sop, in_eop, in_empty, in_valid, in_meta_valid,
               in_meta_dsc_queue, in_meta_pkt_queue, in_meta_drop, pkt_occup, desc_occup,
        input  in_ready, in_meta_ready, pkt_wr_en, pkt_wr_data, pkt_wr_sop, pkt_wr_eop,
               desc_wr_en, desc_wr_dsc_queue, desc_wr_pkt_queue, desc_wr_bytes, desc_wr_flits,
               desc_wr_trunc, stat_pkts, stat_drops, stat_truncs
    );
endinterface

// File: rtl/pdu_gen_param.sv
// PDU generator: byte-swapped flits + one descriptor per packet; flits land 3 cycles after accept.
// in_ready drops combinationally when either ring buffer is almost full; stalls allowed mid-packet.
module pdu_gen_param #(
    parameter int DATA_W        = 512,
    parameter int EMPTY_W       = 6,
    parameter int DSC_QW        = 11,
    parameter int PKT_QW        = 13,
    parameter int RB_AW         = 10,
    parameter int MAX_PKT_FLITS = 24,
    parameter int SWAP_BYTES    = 1,
    parameter int PIPE_SLACK    = 4
) (
    input logic             clk,
    input logic             rst_n,
    pdu_gen_param_if.slave  bus
);
    localparam int BYTES    = DATA_W / 8;
    localparam int RB_DEPTH = 2 ** RB_AW;
    localparam logic [RB_AW:0] PKT_AF    = (RB_AW + 1)'(RB_DEPTH - PIPE_SLACK - MAX_PKT_FLITS);
    localparam logic [RB_AW:0] DSC_AF    = (RB_AW + 1)'(RB_DEPTH - PIPE_SLACK - 1);
    localparam logic [15:0]    BYTES16   = 16'(BYTES);
    localparam logic [15:0]    MAX16     = 16'(MAX_PKT_FLITS);
    localparam logic [15:0]    TRUNC_LEN = 16'(MAX_PKT_FLITS * BYTES);

    typedef enum logic [1:0] {IDLE, ACTIVE, DROP, TRUNC} state_t;

    typedef struct packed {
        logic              wr;
        logic              sop;
        logic              eop;
        logic [DATA_W-1:0] dat;
        logic              dvld;
        logic [DSC_QW-1:0] dq;
        logic [PKT_QW-1:0] pq;
        logic [15:0]       bytes;
        logic [15:0]       flits;
        logic              trunc;
    } stg_t;

    state_t             state, state_nxt;
    logic [15:0]        cnt, cnt_nxt, wr_cnt;
    logic [EMPTY_W-1:0] empty;
    logic [DATA_W-1:0]  swapped;
    logic               almost_full, acc, do_wr, drop_evt, meta_rdy;
    stg_t               s0;
    stg_t               pipe [3];
    logic [31:0]        stat_pkts, stat_drops, stat_truncs;

    assign empty       = bus.in_empty;
    assign almost_full = ({1'b0, bus.pkt_occup} >= PKT_AF) || ({1'b0, bus.desc_occup} >= DSC_AF);
    assign acc         = bus.in_valid & bus.in_meta_valid & ~almost_full;

    always_comb begin
        swapped = bus.in_data;
        if (SWAP_BYTES != 0) begin
            for (int i = 0; i < BYTES; i++) swapped[8*i +: 8] = bus.in_data[8*(BYTES-1-i) +: 8];
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wr_cnt    = cnt + 16'd1;
        do_wr     = 1'b0;
        drop_evt  = 1'b0;
        s0        = '0;
        if (acc) begin
            // A sop always restarts, silently abandoning whatever packet was open.
            if (bus.in_sop) begin
                wr_cnt = 16'd1;
                if (bus.in_meta_drop) begin
                    state_nxt = bus.in_eop ? IDLE : DROP;
                    drop_evt  = bus.in_eop;
                end else begin
                    do_wr = 1'b1;
                end
            end else begin
                case (state)
                    ACTIVE: do_wr = 1'b1;
                    DROP: if (bus.in_eop) begin
                        state_nxt = IDLE;
                        drop_evt  = 1'b1;
                    end
                    TRUNC: if (bus.in_eop) begin
                        state_nxt = IDLE;
                        s0.dvld   = 1'b1;
                        s0.bytes  = TRUNC_LEN;
                        s0.flits  = MAX16;
                        s0.trunc  = 1'b1;
                    end
                    default: ;
                endcase
            end
            if (do_wr) begin
                cnt_nxt = wr_cnt;
                s0.wr   = 1'b1;
                s0.sop  = bus.in_sop;
                s0.dat  = swapped;
                if (bus.in_eop) begin
                    state_nxt = IDLE;
                    s0.eop    = 1'b1;
                    s0.dvld   = 1'b1;
                    s0.bytes  = (wr_cnt * BYTES16) - 16'(empty);
                    s0.flits  = wr_cnt;
                end else if (wr_cnt == MAX16) begin
                    state_nxt = TRUNC;
                    s0.eop    = 1'b1;
                end else begin
                    state_nxt = ACTIVE;
                end
            end
            if (s0.dvld) begin
                s0.dq = bus.in_meta_dsc_queue;
                s0.pq = bus.in_meta_pkt_queue;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            meta_rdy    <= 1'b0;
            stat_pkts   <= '0;
            stat_drops  <= '0;
            stat_truncs <= '0;
            for (int i = 0; i < 3; i++) pipe[i] <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            meta_rdy <= acc & bus.in_eop;
            pipe[0]  <= s0;
            pipe[1]  <= pipe[0];
            pipe[2]  <= pipe[1];
            if (drop_evt) stat_drops <= stat_drops + 32'd1;
            // Counted on entry to the output stage so stats move with desc_wr_en.
            if (pipe[1].dvld) begin
                stat_pkts <= stat_pkts + 32'd1;
                if (pipe[1].trunc) stat_truncs <= stat_truncs + 32'd1;
            end
        end
    end

    assign bus.in_ready          = ~almost_full;
    assign bus.in_meta_ready     = meta_rdy;
    assign bus.pkt_wr_en         = pipe[2].wr;
    assign bus.pkt_wr_data       = pipe[2].dat;
    assign bus.pkt_wr_sop        = pipe[2].sop;
    assign bus.pkt_wr_eop        = pipe[2].eop;
    assign bus.desc_wr_en        = pipe[2].dvld;
    assign bus.desc_wr_dsc_queue = pipe[2].dq;
    assign bus.desc_wr_pkt_queue = pipe[2].pq;
    assign bus.desc_wr_bytes     = pipe[2].bytes;
    assign bus.desc_wr_flits     = pipe[2].flits;
    assign bus.desc_wr_trunc     = pipe[2].trunc;
    assign bus.stat_pkts         = stat_pkts;
    assign bus.stat_drops        = stat_drops;
    assign bus.stat_truncs       = stat_truncs;
endmodule

// File: tb/tb_pdu_gen_param.sv
// Bench for pdu_gen_param (MAX_PKT_FLITS=4): packet-level reference model, expectation queues
// checked every cycle by a monitor, flow-control table, and hand-written corner sequences.
module tb_pdu_gen_param;
    localparam int BYTES    = 64;
    localparam int MAXF     = 4;
    localparam int RB_DEPTH = 1024;
    localparam int SLACK    = 4;
    localparam int AF_PKT   = RB_DEPTH - SLACK - MAXF;
    localparam int AF_DSC   = RB_DEPTH - SLACK - 1;

    typedef struct { int cyc; logic [511:0] dat; logic sop; logic eop; } wexp_t;
    typedef struct { int cyc; logic [10:0] dsc; logic [12:0] pkq; logic [15:0] bytes; logic [15:0] flits; logic trunc; } dexp_t;
    typedef struct { int pocc; int docc; bit rdy; } fc_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 1'b0;
    int   e_pkts = 0, e_drops = 0, e_truncs = 0;
    wexp_t wq[$];
    dexp_t dqq[$];
    int    mq[$];

    pdu_gen_param_if bus ();
    pdu_gen_param #(.MAX_PKT_FLITS(MAXF)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [511:0] swap(input logic [511:0] x);
        logic [511:0] r;
        for (int i = 0; i < BYTES; i++) r[8*i +: 8] = x[8*(BYTES-1-i) +: 8];
        return r;
    endfunction

    function automatic logic [511:0] rand_flit();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Compare outputs against whatever the model expects in this cycle; anything else must be idle.
    always @(negedge clk) begin : mon
        wexp_t w;
        dexp_t d;
        if (mon_on) begin
            if (wq.size() > 0 && wq[0].cyc == cyc) begin
                w = wq.pop_front();
                chk("pkt_wr_en", 512'(bus.pkt_wr_en), 512'(1));
                chk("pkt_wr_data", bus.pkt_wr_data, w.dat);
                chk("pkt_wr_sop", 512'(bus.pkt_wr_sop), 512'(w.sop));
                chk("pkt_wr_eop", 512'(bus.pkt_wr_eop), 512'(w.eop));
            end else if (bus.pkt_wr_en !== 1'b0) begin
                chk("pkt_wr_en_unexpected", 512'(bus.pkt_wr_en), 512'(0));
            end
            if (dqq.size() > 0 && dqq[0].cyc == cyc) begin
                d = dqq.pop_front();
                chk("desc_wr_en", 512'(bus.desc_wr_en), 512'(1));
                chk("desc_dsc_queue", 512'(bus.desc_wr_dsc_queue), 512'(d.dsc));
                chk("desc_pkt_queue", 512'(bus.desc_wr_pkt_queue), 512'(d.pkq));
                chk("desc_bytes", 512'(bus.desc_wr_bytes), 512'(d.bytes));
                chk("desc_flits", 512'(bus.desc_wr_flits), 512'(d.flits));
                chk("desc_trunc", 512'(bus.desc_wr_trunc), 512'(d.trunc));
            end else if (bus.desc_wr_en !== 1'b0) begin
                chk("desc_wr_en_unexpected", 512'(bus.desc_wr_en), 512'(0));
            end
            if (mq.size() > 0 && mq[0] == cyc) begin
                void'(mq.pop_front());
                chk("in_meta_ready", 512'(bus.in_meta_ready), 512'(1));
            end else if (bus.in_meta_ready !== 1'b0) begin
                chk("in_meta_ready_unexpected", 512'(bus.in_meta_ready), 512'(0));
            end
        end
    end

    // One input cycle; acceptance is decided by the bench's own almost-full rule.
    task automatic step(input bit v, input bit mv, input bit sop, input bit eop, input logic [5:0] emp,
                        input logic [511:0] d, input logic [10:0] dsc, input logic [12:0] pkq,
                        input bit drp, input int pocc, input int docc, output bit acc, output int c);
        bit er;
        @(negedge clk);
        bus.in_valid          = v;
        bus.in_meta_valid     = mv;
        bus.in_sop            = sop;
        bus.in_eop            = eop;
        bus.in_empty          = emp;
        bus.in_data           = d;
        bus.in_meta_dsc_queue = dsc;
        bus.in_meta_pkt_queue = pkq;
        bus.in_meta_drop      = drp;
        bus.pkt_occup         = 10'(pocc);
        bus.desc_occup        = 10'(docc);
        #1;
        er = !(pocc >= AF_PKT || docc >= AF_DSC);
        chk("in_ready", 512'(bus.in_ready), 512'(er));
        acc = v && mv && er;
        c   = cyc;
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        bit a;
        int c;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, '0, '0, '0, 0, 0, 0, a, c);
    endtask

    // Packet-level model: which flits get written, and what the descriptor says.
    task automatic send_pkt(input int n, input logic [5:0] emp, input logic [10:0] dsc, input logic [12:0] pkq,
                            input bit drp, input int stall_pct, input bit gap1);
        int w, c, tries, pocc, docc;
        bit tr, acc, v, mv;
        logic [511:0] d;
        wexp_t we;
        dexp_t de;
        c  = 0;
        w  = drp ? 0 : (n < MAXF ? n : MAXF);
        tr = !drp && (n > MAXF);
        for (int k = 0; k < n; k++) begin
            d = rand_flit();
            if (k == 0) d[7:0] = 8'h11;
            acc   = 1'b0;
            tries = 0;
            while (!acc) begin
                if (tries == 100) begin
                    chk("accept_timeout", 512'(0), 512'(1));
                    return;
                end
                tries++;
                v    = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
                mv   = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
                pocc = (stall_pct != 0 && $urandom_range(7) == 0) ? AF_PKT + int'($urandom_range(7)) : int'($urandom_range(AF_PKT - 1));
                docc = (stall_pct != 0 && $urandom_range(9) == 0) ? AF_DSC + int'($urandom_range(4)) : int'($urandom_range(AF_DSC - 1));
                step(v, mv, k == 0, k == n - 1, emp, d, dsc, pkq, drp, pocc, docc, acc, c);
            end
            if (gap1 && k == 0) idle(1);
            if (k < w) begin
                we.cyc = c + 3; we.dat = swap(d); we.sop = (k == 0); we.eop = (k == w - 1);
                wq.push_back(we);
            end
        end
        mq.push_back(c + 1);
        if (drp) begin
            e_drops++;
        end else begin
            de.cyc   = c + 3;
            de.dsc   = dsc;
            de.pkq   = pkq;
            de.flits = 16'(w);
            de.bytes = tr ? 16'(w * BYTES) : 16'(w * BYTES - int'(emp));
            de.trunc = tr;
            dqq.push_back(de);
            e_pkts++;
            if (tr) e_truncs++;
        end
    endtask

    task automatic chk_stats();
        chk("stat_pkts", 512'(bus.stat_pkts), 512'(e_pkts));
        chk("stat_drops", 512'(bus.stat_drops), 512'(e_drops));
        chk("stat_truncs", 512'(bus.stat_truncs), 512'(e_truncs));
    endtask

    initial begin
        fc_t          fc [8];
        bit           acc;
        int           c;
        logic [511:0] d;
        wexp_t        we;

        fc[0] = '{AF_PKT,     0,          1'b0};
        fc[1] = '{AF_PKT - 1, 0,          1'b1};
        fc[2] = '{1023,       0,          1'b0};
        fc[3] = '{0,          AF_DSC,     1'b0};
        fc[4] = '{0,          AF_DSC - 1, 1'b1};
        fc[5] = '{0,          1023,       1'b0};
        fc[6] = '{AF_PKT - 1, AF_DSC - 1, 1'b1};
        fc[7] = '{0,          0,          1'b1};

        bus.in_valid = 0; bus.in_meta_valid = 0; bus.in_sop = 0; bus.in_eop = 0; bus.in_empty = '0;
        bus.in_data = '0; bus.in_meta_dsc_queue = '0; bus.in_meta_pkt_queue = '0; bus.in_meta_drop = 0;
        bus.pkt_occup = '0; bus.desc_occup = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pkt_wr_en", 512'(bus.pkt_wr_en), 512'(0));
        chk("rst_pkt_wr_data", bus.pkt_wr_data, 512'(0));
        chk("rst_desc_wr_en", 512'(bus.desc_wr_en), 512'(0));
        chk("rst_desc_dsc_queue", 512'(bus.desc_wr_dsc_queue), 512'(0));
        chk("rst_in_meta_ready", 512'(bus.in_meta_ready), 512'(0));
        chk("rst_in_ready", 512'(bus.in_ready), 512'(1));
        chk_stats();
        rst_n  = 1'b1;
        mon_on = 1'b1;

        send_pkt(1, 6'd4, 11'd3, 13'd7, 0, 0, 0);        idle(6); chk_stats();
        send_pkt(3, 6'd10, 11'd100, 13'd200, 0, 0, 1);   idle(6); chk_stats();
        send_pkt(2, 6'd0, 11'd1, 13'd2, 1, 0, 0);        idle(6); chk_stats();
        send_pkt(6, 6'd5, 11'd9, 13'd11, 0, 0, 0);       idle(6); chk_stats();
        send_pkt(4, 6'd63, 11'd12, 13'd13, 0, 0, 0);     idle(6); chk_stats();

        // Thresholds: single-flit drop packets only complete when in_ready is high.
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 1, 1, '0, '0, '0, '0, 1, fc[i].pocc, fc[i].docc, acc, c);
            chk("fc_in_ready", 512'(bus.in_ready), 512'(fc[i].rdy));
            if (acc) begin
                mq.push_back(c + 1);
                e_drops++;
            end
        end
        idle(6); chk_stats();

        // Sop inside an open packet: old flits stay written, no descriptor for them.
        d = rand_flit();
        step(1, 1, 1, 0, '0, d, 11'd5, 13'd9, 0, 0, 0, acc, c);
        we.cyc = c + 3; we.dat = swap(d); we.sop = 1'b1; we.eop = 1'b0; wq.push_back(we);
        d = rand_flit();
        step(1, 1, 0, 0, '0, d, 11'd5, 13'd9, 0, 0, 0, acc, c);
        we.cyc = c + 3; we.dat = swap(d); we.sop = 1'b0; we.eop = 1'b0; wq.push_back(we);
        send_pkt(1, 6'd0, 11'd6, 13'd10, 0, 0, 0);
        idle(6); chk_stats();

        // Reset lands while two flits are still in the pipeline.
        step(1, 1, 1, 0, '0, rand_flit(), 11'd2, 13'd3, 0, 0, 0, acc, c);
        step(1, 1, 0, 0, '0, rand_flit(), 11'd2, 13'd3, 0, 0, 0, acc, c);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_pkt_wr_en", 512'(bus.pkt_wr_en), 512'(0));
        e_pkts = 0; e_drops = 0; e_truncs = 0;
        chk_stats();
        idle(6);
        send_pkt(1, 6'd4, 11'd3, 13'd7, 0, 0, 0);        idle(6); chk_stats();

        for (int p = 0; p < 40; p++) begin
            send_pkt(int'($urandom_range(7, 1)), 6'($urandom_range(63)), 11'($urandom), 13'($urandom),
                     $urandom_range(4) == 0, 25, 0);
        end
        idle(8);
        chk_stats();
        chk("wq_drained", 512'(wq.size()), 512'(0));
        chk("dq_drained", 512'(dqq.size()), 512'(0));
        chk("mq_drained", 512'(mq.size()), 512'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
